// File: rtl/mole_round_scheduler_if.sv
// ----------------------------------------------------------------------------
// mole_round_scheduler_if
//   Bundles the game-control signals of the mole round scheduler.
//   master : the game-level driver (start pulse, debounced buttons)
//   slave  : the scheduler (lit mole, hit/miss pulses, score, status)
// Signals
//   start      master->slave  1-cycle pulse, begins a game from IDLE/DONE
//   btn        master->slave  debounced buttons, level, 1 = pressed
//   mole_oh    slave->master  one-hot lit mole, 0 when none
//   hit_pulse  slave->master  1-cycle pulse on a correct hit
//   miss_pulse slave->master  1-cycle pulse on a wrong press or timeout
//   score      slave->master  hits this game, saturating
//   busy       slave->master  high while a round is in progress
//   done       slave->master  high once all rounds are played
// ----------------------------------------------------------------------------
interface mole_round_scheduler_if #(
  parameter int N_MOLES = 4,
  parameter int SCORE_W = 5
);
  logic               start;
  logic [N_MOLES-1:0] btn;
  logic [N_MOLES-1:0] mole_oh;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;

  modport master (
    output start, btn,
    input  mole_oh, hit_pulse, miss_pulse, score, busy, done
  );

  modport slave (
    input  start, btn,
    output mole_oh, hit_pulse, miss_pulse, score, busy, done
  );
endinterface

// File: rtl/mole_round_scheduler.sv
// ----------------------------------------------------------------------------
// mole_round_scheduler
//   Game sequencer for whack-a-mole. Plays ROUNDS rounds; each round waits a
//   dark gap, lights one pseudo-randomly chosen mole, then judges the button
//   response (hit / wrong press / timeout). Every hit shortens the show window
//   by ON_STEP ticks down to ON_MIN.
// Ports
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   bus  slave modport of mole_round_scheduler_if (start, btn in;
//        mole_oh, hit_pulse, miss_pulse, score, busy, done out)
// ----------------------------------------------------------------------------
module mole_round_scheduler #(
  parameter int N_MOLES  = 4,
  parameter int TICK_DIV = 1000,
  parameter int GAP_T    = 300,
  parameter int ON_INIT  = 800,
  parameter int ON_MIN   = 200,
  parameter int ON_STEP  = 50,
  parameter int ROUNDS   = 16,
  parameter int SCORE_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  mole_round_scheduler_if.slave  bus
);

  localparam int SEL_W = $clog2(N_MOLES);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int MAX_T = (GAP_T > ON_INIT) ? GAP_T : ON_INIT;
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PRE_W-1:0]   r_presc;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [CNT_W-1:0]   r_on_len;
  logic [7:0]         r_lfsr;
  logic [7:0]         r_round_cnt;
  logic [N_MOLES-1:0] r_btn_q;
  logic [N_MOLES-1:0] r_press;
  logic [N_MOLES-1:0] r_mole_oh;
  logic               r_hit_pulse;
  logic               r_miss_pulse;
  logic [SCORE_W-1:0] r_score;

  logic w_tick, w_gap_end, w_show_end, w_wrong;
  logic w_hit, w_miss, w_new_game, w_lfsr_fb;

  assign w_tick     = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_gap_end  = w_tick && (r_tick_cnt == CNT_W'(GAP_T - 1));
  assign w_show_end = w_tick && (r_tick_cnt == r_on_len - CNT_W'(1));
  // Any pressed bit off the lit mole is a wrong press, even alongside the right one.
  assign w_wrong    = |(r_press & ~r_mole_oh);
  // Taps 8,6,5,4: a non-zero seed never reaches the all-zero lock-up state.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_new_game  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_GAP;
          w_new_game  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_end) w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (w_wrong)         w_miss = 1'b1;
        else if (|r_press)   w_hit  = 1'b1;
        else if (w_show_end) w_miss = 1'b1;
        if (w_hit || w_miss)
          w_state_nxt = (r_round_cnt == 8'(ROUNDS - 1)) ? S_DONE : S_GAP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_tick_cnt   <= '0;
      r_on_len     <= CNT_W'(ON_INIT);
      r_lfsr       <= 8'hA5;
      r_round_cnt  <= '0;
      r_btn_q      <= '0;
      r_press      <= '0;
      r_mole_oh    <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_score      <= '0;
    end else begin
      r_btn_q      <= bus.btn;
      // Press edges are only collected while a mole is shown; this register is
      // the first of the two stages between a press and its pulse.
      r_press      <= (r_state == S_SHOW) ? (bus.btn & ~r_btn_q) : '0;
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;

      // Prescaler restarts on every state entry so intervals are exact tick multiples.
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_presc    <= '0;
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_presc    <= '0;
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end else begin
        r_presc    <= r_presc + PRE_W'(1);
      end

      if (w_new_game) begin
        r_score     <= '0;
        r_round_cnt <= '0;
        r_on_len    <= CNT_W'(ON_INIT);
      end

      if ((r_state == S_GAP) && w_gap_end)
        r_mole_oh <= N_MOLES'(1) << r_lfsr[SEL_W-1:0];

      if (w_hit || w_miss) begin
        r_mole_oh   <= '0;
        r_round_cnt <= r_round_cnt + 8'd1;
      end

      if (w_hit) begin
        if (r_score != '1) r_score <= r_score + SCORE_W'(1);
        if (int'(r_on_len) >= ON_MIN + ON_STEP) r_on_len <= r_on_len - CNT_W'(ON_STEP);
        else                                    r_on_len <= CNT_W'(ON_MIN);
      end
    end
  end

  assign bus.mole_oh    = r_mole_oh;
  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.score      = r_score;
  assign bus.busy       = (r_state == S_GAP) || (r_state == S_SHOW);
  assign bus.done       = (r_state == S_DONE);

endmodule
